// File: rtl/genius_pkg.sv
// Shared constants for the user-input checker: colour codes, FSM states,
// parameter defaults and one-hot helpers.
package genius_pkg;

  localparam int unsigned DEB_CYC_DEF = 4;
  localparam int unsigned TMO_CYC_DEF = 1000;

  localparam logic [1:0] COL_0 = 2'd0;
  localparam logic [1:0] COL_1 = 2'd1;
  localparam logic [1:0] COL_2 = 2'd2;
  localparam logic [1:0] COL_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_WAIT_RELEASE = 2'd2
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

  // Only meaningful for one-hot inputs.
  function automatic logic [1:0] enc_color(input logic [3:0] v);
    logic [1:0] c;
    c = COL_0;
    case (v)
      4'b0010: c = COL_1;
      4'b0100: c = COL_2;
      4'b1000: c = COL_3;
      default: c = COL_0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Debouncer: output follows the input only once the input has held the same
// value for DEB_CYC consecutive samples.
module btn_debounce #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned CW = $clog2(DEB_CYC + 1);

  logic [WIDTH-1:0] cand_q, cand_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] db_q, db_d;

  // Track run length of the current candidate; commit it once long enough.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    db_d   = db_q;
    if (din != cand_q) begin
      cand_d = din;
      cnt_d  = CW'(1);
    end else if (cnt_q < CW'(DEB_CYC)) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (cnt_d >= CW'(DEB_CYC)) begin
      db_d = din;
    end
  end

  // State registers, synchronously cleared.
  always_ff @(posedge clk) begin
    if (R) begin
      cand_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/user_input_checker.sv
// Checks a user's button presses against the expected colour sequence for
// one turn, pulsing step per correct press, ok on completion, err on failure.
module user_input_checker
  import genius_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF,
  parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
  input  logic       clk,
  input  logic       R,
  input  logic       start,
  input  logic [3:0] round_len,
  input  logic [3:0] btn,
  input  logic [1:0] exp_color,
  output logic [3:0] addr,
  output logic       step,
  output logic       ok,
  output logic       err,
  output logic       busy
);

  localparam int unsigned TW = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    db;
  state_e        state_q;
  logic [3:0]    addr_q, len_q;
  logic [TW-1:0] tmo_q;
  logic          armed_q;
  logic          step_q, ok_q, err_q, busy_q;

  // Two-flop synchroniser for the raw buttons.
  always_ff @(posedge clk) begin
    if (R) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  btn_debounce #(
    .WIDTH  (4),
    .DEB_CYC(DEB_CYC)
  ) u_deb (
    .clk (clk),
    .R   (R),
    .din (sync2_q),
    .dout(db)
  );

  // Turn FSM with registered pulse outputs.
  // armed_q records that db has been seen at 0 in this wait, so a press held
  // over from before start (or from a previous press) is not evaluated; the
  // timeout counter saturates while such a held press blocks the db==0 check.
  always_ff @(posedge clk) begin
    if (R) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
      armed_q <= 1'b0;
      step_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (round_len != '0) begin
              len_q   <= round_len;
              addr_q  <= '0;
              tmo_q   <= '0;
              armed_q <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= ST_WAIT_PRESS;
            end else begin
              ok_q <= 1'b1;
            end
          end
        end
        ST_WAIT_PRESS: begin
          if (db == '0) begin
            armed_q <= 1'b1;
            if (tmo_q == TMO_LAST) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              tmo_q <= tmo_q + TW'(1);
            end
          end else if (armed_q) begin
            if (is_onehot4(db) && (enc_color(db) == exp_color)) begin
              step_q  <= 1'b1;
              state_q <= ST_WAIT_RELEASE;
            end else begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else if (tmo_q != TMO_LAST) begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        ST_WAIT_RELEASE: begin
          if (db == '0) begin
            if (addr_q == (len_q - 4'd1)) begin
              ok_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              addr_q  <= addr_q + 4'd1;
              tmo_q   <= '0;
              armed_q <= 1'b1;
              state_q <= ST_WAIT_PRESS;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign addr = addr_q;
  assign step = step_q;
  assign ok   = ok_q;
  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_user_input_checker.sv
// Directed bench for user_input_checker with an event scoreboard.
module tb_user_input_checker;

  localparam int unsigned DEB = 4;
  localparam int unsigned TMO = 40;
  localparam int LAT = DEB + 3;   // btn edge to pulse, in clock edges

  localparam int K_NONE = 0;
  localparam int K_STEP = 1;
  localparam int K_OK   = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [3:0] a;
  } ev_t;

  logic       clk = 1'b0;
  logic       R;
  logic       start;
  logic [3:0] round_len;
  logic [3:0] btn;
  logic [1:0] exp_color;
  logic [3:0] addr;
  logic       step, ok, err, busy;

  logic [1:0] mem [16];
  ev_t        evq[$];
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  assign exp_color = mem[addr];

  user_input_checker #(
    .DEB_CYC(DEB),
    .TMO_CYC(TMO)
  ) dut (
    .clk      (clk),
    .R        (R),
    .start    (start),
    .round_len(round_len),
    .btn      (btn),
    .exp_color(exp_color),
    .addr     (addr),
    .step     (step),
    .ok       (ok),
    .err      (err),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int kind, input int at, input logic [3:0] a);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    e.a    = a;
    evq.push_back(e);
  endtask

  task automatic drive_btn(input logic [3:0] v, input int kind, input logic [3:0] a);
    btn = v;
    if (kind != K_NONE) push(kind, cyc + LAT, a);
    tick(LAT + 2);
  endtask

  task automatic do_start(input logic [3:0] len);
    round_len = len;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Scoreboard: every output pulse must match the next expected event.
  always @(negedge clk) begin
    int kobs;
    ev_t e;
    if (step || ok || err) begin
      kobs = step ? K_STEP : (ok ? K_OK : K_ERR);
      chk("pulse_exclusive", 32'({step, ok, err} == 3'b100 || {step, ok, err} == 3'b010 ||
                                 {step, ok, err} == 3'b001), 32'd1);
      if (evq.size() == 0) begin
        chk("unexpected_pulse", 32'(kobs), 32'(K_NONE));
      end else begin
        e = evq.pop_front();
        chk("pulse_kind", 32'(kobs), 32'(e.kind));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        chk("pulse_addr", 32'(addr), 32'(e.a));
      end
    end
  end

  initial begin
    R = 1'b1;
    start = 1'b0;
    round_len = '0;
    btn = '0;
    for (int i = 0; i < 16; i++) mem[i] = 2'd0;

    // Reset for two cycles.
    tick(2);
    R = 1'b0;
    tick(1);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_pulses", 32'({step, ok, err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Clean three-press turn; a start in mid-turn is ignored.
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd1;
    do_start(4'd3);
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_addr0", 32'(addr), 32'd0);
    drive_btn(4'b0100, K_STEP, 4'd0);
    round_len = 4'd0;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    drive_btn(4'b0000, K_NONE, 4'd0);
    chk("t3_addr1", 32'(addr), 32'd1);
    drive_btn(4'b0001, K_STEP, 4'd1);
    drive_btn(4'b0000, K_NONE, 4'd0);
    chk("t3_addr2", 32'(addr), 32'd2);
    drive_btn(4'b0010, K_STEP, 4'd2);
    drive_btn(4'b0000, K_OK, 4'd2);
    chk("t3_done_busy", 32'(busy), 32'd0);
    chk("t3_done_addr", 32'(addr), 32'd2);

    // Wrong colour.
    mem[0] = 2'd1;
    do_start(4'd2);
    drive_btn(4'b1000, K_ERR, 4'd0);
    chk("wrong_busy", 32'(busy), 32'd0);
    drive_btn(4'b0000, K_NONE, 4'd0);

    // Multi-press.
    mem[0] = 2'd0;
    do_start(4'd1);
    drive_btn(4'b0011, K_ERR, 4'd0);
    chk("multi_busy", 32'(busy), 32'd0);
    drive_btn(4'b0000, K_NONE, 4'd0);

    // Timeout with no press.
    push(K_ERR, cyc + 1 + TMO, 4'd0);
    do_start(4'd1);
    tick(TMO + 2);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Zero-length turn.
    push(K_OK, cyc + 1, 4'd0);
    do_start(4'd0);
    chk("len0_busy", 32'(busy), 32'd0);
    tick(2);

    // Press held across start is not accepted until released.
    mem[0] = 2'd2;
    btn = 4'b0100;
    tick(LAT + 2);
    do_start(4'd1);
    tick(LAT + 2);
    chk("held_busy", 32'(busy), 32'd1);
    drive_btn(4'b0000, K_NONE, 4'd0);
    drive_btn(4'b0100, K_STEP, 4'd0);
    drive_btn(4'b0000, K_OK, 4'd0);

    // Glitch shorter than the debounce window.
    do_start(4'd1);
    btn = 4'b0100;
    tick(DEB - 1);
    btn = 4'b0000;
    tick(LAT + 3);
    chk("glitch_busy", 32'(busy), 32'd1);
    chk("glitch_addr", 32'(addr), 32'd0);
    drive_btn(4'b0100, K_STEP, 4'd0);
    drive_btn(4'b0000, K_OK, 4'd0);

    // Reset while waiting for release at addr 1.
    mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd1;
    do_start(4'd3);
    drive_btn(4'b0100, K_STEP, 4'd0);
    drive_btn(4'b0000, K_NONE, 4'd0);
    chk("mid_addr1", 32'(addr), 32'd1);
    drive_btn(4'b0001, K_STEP, 4'd1);
    R = 1'b1;
    tick(1);
    chk("midrst_addr", 32'(addr), 32'd0);
    chk("midrst_pulses", 32'({step, ok, err}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    R = 1'b0;
    btn = 4'b0000;
    tick(LAT + 3);
    chk("post_rst_busy", 32'(busy), 32'd0);

    chk("events_pending", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/user_input_checker.md
USER_INPUT_CHECKER -- requirements
Module: user_input_checker

Interface
REQ-001 SHALL have parameter DEB_CYC, default 4, meaning cycles a raw button vector must stay stable before it is accepted.
REQ-002 SHALL have parameter TMO_CYC, default 1000, meaning the maximum number of cycles allowed in WAIT_PRESS before a timeout error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port R, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request that begins a user turn.
REQ-006 SHALL have port round_len, input, 4 bits: number of presses in this turn; it is sampled at start.
REQ-007 SHALL have port btn, input, 4 bits: raw buttons, one-hot per colour, bit i = colour i.
REQ-008 SHALL have port exp_color, input, 2 bits: expected colour at addr, from sequence memory, valid combinationally.
REQ-009 SHALL have port addr, output, 4 bits: index of the press currently expected.
REQ-010 SHALL have port step, output, 1 bit: one-cycle pulse per correct press; it drives the E input of the user counter.
REQ-011 SHALL have port ok, output, 1 bit: one-cycle pulse when the turn completes correctly.
REQ-012 SHALL have port err, output, 1 bit: one-cycle pulse on a wrong press, a multi-press or a timeout.
REQ-013 SHALL have port busy, output, 1 bit: high while the turn is in progress, in states other than IDLE.

Function
REQ-014 SHALL pass btn through a 2-flop synchroniser, then a debouncer; the debounced vector db updates only after DEB_CYC consecutive identical samples.
REQ-015 SHALL implement the FSM states IDLE, WAIT_PRESS and WAIT_RELEASE.
REQ-016 IDLE: on start with round_len != 0, the block SHALL latch round_len, clear addr to 0, clear the timeout counter and go to WAIT_PRESS.
REQ-017 IDLE: on start with round_len == 0, the block SHALL pulse ok on the next cycle and remain in IDLE.
REQ-018 WAIT_PRESS: the timeout counter SHALL increment each cycle; on reaching TMO_CYC-1 with db == 0, err SHALL pulse next cycle and the FSM SHALL go to IDLE.
REQ-019 WAIT_PRESS: when db becomes nonzero and is not one-hot, err SHALL pulse next cycle and the FSM SHALL go to IDLE.
REQ-020 WAIT_PRESS: when db is one-hot and its encoded colour != exp_color, err SHALL pulse next cycle and the FSM SHALL go to IDLE.
REQ-021 WAIT_PRESS: when db is one-hot and matches exp_color, step SHALL pulse next cycle and the FSM SHALL go to WAIT_RELEASE.
REQ-022 WAIT_RELEASE: the FSM SHALL wait for db == 0; no timeout applies; any other db change SHALL be ignored.
REQ-023 On release, if addr == latched_len-1: ok SHALL pulse next cycle, addr SHALL stay unchanged and the FSM SHALL go to IDLE.
REQ-024 On release when that condition does not hold: addr SHALL increment by 1, the timeout counter SHALL clear and the FSM SHALL return to WAIT_PRESS.
REQ-025 addr SHALL be 4 bits and never wraps, since latched_len <= 15 bounds it.
REQ-026 start SHALL be ignored while busy is high.
REQ-027 step, ok and err SHALL be registered and mutually exclusive, each at most one cycle wide.
REQ-028 A press already held at start SHALL be accepted only after db has been 0 once; WAIT_PRESS requires a 0->nonzero db transition.

Reset
REQ-029 With R high at a clk edge, the FSM SHALL go to IDLE; addr, step, ok, err, busy, the timeout counter, the debouncer state and the synchroniser flops SHALL all be cleared to 0.
REQ-030 R SHALL take priority over start and over any in-flight press; a reset mid-turn SHALL not emit step, ok or err.

Structure
REQ-031 The colour encoding constants, the FSM state encoding, and the DEB_CYC/TMO_CYC defaults SHALL live in a shared package, genius_pkg.
REQ-032 The debouncer SHALL be a sub-module, btn_debounce, of width 4, parameter DEB_CYC, ports clk/R.

Verification
REQ-033 R=1 for 2 cycles, then R=0 -> all outputs are 0 and busy=0.
REQ-034 round_len=3, exp_color sequence 2,0,1, clean presses btn=0100, 0001, 0010 with releases -> three step pulses, addr 0->1->2, then ok, busy falls.
REQ-035 round_len=2, first press btn=1000 with exp_color=1 -> err pulse one cycle after db change, no step, busy=0.
REQ-036 round_len=1, btn=0011 -> err; separately, no press for TMO_CYC cycles -> err on cycle TMO_CYC+1 after start.
REQ-037 btn glitch 0100 for DEB_CYC-1 cycles -> no step and no err; round_len=0 with start -> ok next cycle and busy remains 0.
REQ-038 R asserted in WAIT_RELEASE at addr=1 -> outputs are 0 next cycle with no step, ok or err.
